// File: rtl/soc_system_avalon_st_data_packer_8to24.sv
// Avalon-ST width adapter: packs a stream of 8-bit symbols into 24-bit beats
// (three symbols per beat, first symbol in the most significant byte).
// Partial final beats are zero-filled and report unused symbols on out_empty.
// A start-of-packet arriving mid-beat abandons the partial beat and restarts.
module soc_system_avalon_st_data_packer_8to24 (
    input  logic        clk,
    input  logic        reset_n,

    output logic        in_ready,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,

    input  logic        out_ready,
    output logic        out_valid,
    output logic [23:0] out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [1:0]  out_empty
);

    // Accumulator state
    logic [1:0]  r_cnt;
    logic [7:0]  r_slot0;
    logic [7:0]  r_slot1;
    logic        r_sop_pend;

    // Output beat register
    logic        r_out_valid;
    logic [23:0] r_out_data;
    logic        r_out_sop;
    logic        r_out_eop;
    logic [1:0]  r_out_empty;

    // Handshake and beat-assembly wires
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic [1:0]  w_eff_cnt;
    logic        w_emit;
    logic [23:0] w_beat_data;
    logic        w_beat_sop;
    logic [1:0]  w_beat_empty;

    // The output register can take a new beat whenever it is empty or draining.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // A start-of-packet symbol always lands in the first position of a fresh beat.
    assign w_eff_cnt  = in_startofpacket ? 2'd0 : r_cnt;
    assign w_emit     = w_in_xfer && ((w_eff_cnt == 2'd2) || in_endofpacket);

    // Assemble the beat that would be loaded if this symbol completes it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_beat_data  = 24'h000000;
        w_beat_sop   = r_sop_pend;
        w_beat_empty = 2'd2 - w_eff_cnt;
        case (w_eff_cnt)
            2'd0: begin
                w_beat_data = {in_data, 16'h0000};
                w_beat_sop  = in_startofpacket;
            end
            2'd1:    w_beat_data = {r_slot0, in_data, 8'h00};
            default: w_beat_data = {r_slot0, r_slot1, in_data};
        endcase
    end

    // Collect symbols into the slots until a beat completes.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the slots are data-only storage, but they are reset too so a
        // reset mid-packet leaves no stale symbols behind.
        if (!reset_n) begin
            r_cnt      <= 2'd0;
            r_slot0    <= 8'h00;
            r_slot1    <= 8'h00;
            r_sop_pend <= 1'b0;
        end else if (w_in_xfer) begin
            // NOTE: state uses non-blocking assignments so every register
            // sees the pre-edge values of the others.
            if (w_emit) begin
                r_cnt      <= 2'd0;
                r_sop_pend <= 1'b0;
            end else begin
                if (w_eff_cnt == 2'd0) begin
                    r_slot0    <= in_data;
                    r_sop_pend <= in_startofpacket;
                end else begin
                    r_slot1    <= in_data;
                end
                r_cnt <= w_eff_cnt + 2'd1;
            end
        end
    end

    // Load a completed beat, or retire the held beat once it transfers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 24'h000000;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= 2'd0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_beat_data;
            r_out_sop   <= w_beat_sop;
            r_out_eop   <= in_endofpacket;
            r_out_empty <= w_beat_empty;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_empty         = r_out_empty;

endmodule
